// File: rtl/clock_phase_gen.sv
// clock_phase_gen: NUM_CH glitch-free programmable clock dividers driven from one system clock.
// Optional build macro CLKGEN_INVERT_EN adds a per-channel output inversion bit (cfg_inv).
module clock_phase_gen #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKGEN_INVERT_EN
    input  logic              cfg_inv,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic              cfg_busy,
    output logic              locked
);

    logic [DIV_W-1:0]  cnt_q      [NUM_CH];
    logic [DIV_W-1:0]  cnt_d      [NUM_CH];
    logic [DIV_W-1:0]  div_act_q  [NUM_CH];
    logic [DIV_W-1:0]  div_act_d  [NUM_CH];
    logic [DIV_W-1:0]  div_pend_q [NUM_CH];
    logic [DIV_W-1:0]  div_pend_d [NUM_CH];
    logic [NUM_CH-1:0] raw_q,  raw_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] seen_q, seen_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic              locked_q, locked_d;
    logic [NUM_CH-1:0] we_hit;
    logic [NUM_CH-1:0] at_end;
`ifdef CLKGEN_INVERT_EN
    logic [NUM_CH-1:0] inv_act_q,  inv_act_d;
    logic [NUM_CH-1:0] inv_pend_q, inv_pend_d;
`endif

    // Reset ratio of channel i is /2^(i+1), i.e. half-period minus one = 2^i - 1.
    function automatic logic [DIV_W-1:0] div_default(input int idx);
        return DIV_W'((32'd1 << idx) - 32'd1);
    endfunction

    // A write to a channel number at or above NUM_CH matches no channel and is dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            we_hit[i] = cfg_we && (cfg_ch == 3'(i));
            at_end[i] = (cnt_q[i] >= div_act_q[i]);
        end
    end

    always_comb begin
        raw_d  = raw_q;
        pend_d = pend_q;
        seen_d = seen_q;
        tick_d = '0;
`ifdef CLKGEN_INVERT_EN
        inv_act_d  = inv_act_q;
        inv_pend_d = inv_pend_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            div_act_d[i]  = div_act_q[i];
            div_pend_d[i] = div_pend_q[i];

            if (sync) begin
                // Realign: every channel restarts low with its newest divide value.
                cnt_d[i]  = '0;
                raw_d[i]  = 1'b0;
                seen_d[i] = 1'b0;
                pend_d[i] = 1'b0;
                if (we_hit[i]) begin
                    div_act_d[i]  = cfg_div;
                    div_pend_d[i] = cfg_div;
`ifdef CLKGEN_INVERT_EN
                    inv_act_d[i]  = cfg_inv;
                    inv_pend_d[i] = cfg_inv;
`endif
                end else if (pend_q[i]) begin
                    div_act_d[i] = div_pend_q[i];
`ifdef CLKGEN_INVERT_EN
                    inv_act_d[i] = inv_pend_q[i];
`endif
                end
            end else begin
                if (enable) begin
                    if (at_end[i]) begin
                        cnt_d[i] = '0;
                        raw_d[i] = ~raw_q[i];
                        if (!raw_q[i]) begin
                            tick_d[i] = 1'b1;
                            seen_d[i] = 1'b1;
                        end else if (pend_q[i]) begin
                            // Swap ratios only as the output falls so no pulse is cut short.
                            div_act_d[i] = div_pend_q[i];
                            pend_d[i]    = 1'b0;
`ifdef CLKGEN_INVERT_EN
                            inv_act_d[i] = inv_pend_q[i];
`endif
                        end
                    end else begin
                        cnt_d[i] = cnt_q[i] + DIV_W'(1);
                    end
                end
                if (we_hit[i]) begin
                    div_pend_d[i] = cfg_div;
                    pend_d[i]     = 1'b1;
`ifdef CLKGEN_INVERT_EN
                    inv_pend_d[i] = cfg_inv;
`endif
                end
            end
        end
        locked_d = (&seen_q) && !(|pend_q) && !(|we_hit) && !sync;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_act_q[i]  <= div_default(i);
                div_pend_q[i] <= div_default(i);
            end
            raw_q    <= '0;
            pend_q   <= '0;
            seen_q   <= '0;
            tick_q   <= '0;
            locked_q <= 1'b0;
`ifdef CLKGEN_INVERT_EN
            inv_act_q  <= '0;
            inv_pend_q <= '0;
`endif
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                div_act_q[i]  <= div_act_d[i];
                div_pend_q[i] <= div_pend_d[i];
            end
            raw_q    <= raw_d;
            pend_q   <= pend_d;
            seen_q   <= seen_d;
            tick_q   <= tick_d;
            locked_q <= locked_d;
`ifdef CLKGEN_INVERT_EN
            inv_act_q  <= inv_act_d;
            inv_pend_q <= inv_pend_d;
`endif
        end
    end

`ifdef CLKGEN_INVERT_EN
    assign clk_out = raw_q ^ inv_act_q;
`else
    assign clk_out = raw_q;
`endif
    assign tick     = tick_q;
    assign cfg_busy = |pend_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Testbench for clock_phase_gen: directed scenarios plus random traffic against a
// countdown-style reference model of each divided clock.
module tb_clock_phase_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic              sync;
    logic              cfg_we;
    logic [2:0]        cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_inv;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic              cfg_busy;
    logic              locked;

    int errors = 0;
    int checks = 0;

    // Reference model: each channel counts down the cycles left in its current half-period.
    int m_half      [NUM_CH];
    int m_rem       [NUM_CH];
    int m_pend_half [NUM_CH];
    bit m_lvl       [NUM_CH];
    bit m_pend      [NUM_CH];
    bit m_seen      [NUM_CH];
    bit m_tick      [NUM_CH];
    bit m_inv       [NUM_CH];
    bit m_inv_pend  [NUM_CH];
    bit m_lock;
    int tick_cnt    [NUM_CH];
    logic [NUM_CH-1:0] frozen;

    always #5 clock = ~clock;

    clock_phase_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sync     (sync),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
`ifdef CLKGEN_INVERT_EN
        .cfg_inv  (cfg_inv),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_busy (cfg_busy),
        .locked   (locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_clk();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_lvl[i] ^ m_inv[i];
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_tick();
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = m_tick[i];
        return r;
    endfunction

    function automatic logic exp_busy();
        logic r = 1'b0;
        for (int i = 0; i < NUM_CH; i++) r |= m_pend[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_half[i]      = 1 << i;
            m_rem[i]       = m_half[i];
            m_pend_half[i] = m_half[i];
            m_lvl[i]       = 1'b0;
            m_pend[i]      = 1'b0;
            m_seen[i]      = 1'b0;
            m_tick[i]      = 1'b0;
            m_inv[i]       = 1'b0;
            m_inv_pend[i]  = 1'b0;
        end
        m_lock = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit sy, input bit we, input int ch,
                              input int div, input bit inv);
        bit hit      = we && (ch < NUM_CH);
        bit all_seen = 1'b1;
        bit any_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            all_seen &= m_seen[i];
            any_pend |= m_pend[i];
        end
        if (sy) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit && ch == i) begin
                    m_half[i] = div + 1;
                    m_inv[i]  = inv;
                end else if (m_pend[i]) begin
                    m_half[i] = m_pend_half[i];
                    m_inv[i]  = m_inv_pend[i];
                end
                m_pend[i] = 1'b0;
                m_lvl[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_seen[i] = 1'b0;
                m_rem[i]  = m_half[i];
            end
            m_lock = 1'b0;
        end else begin
            m_lock = all_seen && !any_pend && !hit;
            for (int i = 0; i < NUM_CH; i++) begin
                m_tick[i] = 1'b0;
                if (en) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        if (!m_lvl[i]) begin
                            m_lvl[i]  = 1'b1;
                            m_tick[i] = 1'b1;
                            m_seen[i] = 1'b1;
                        end else begin
                            m_lvl[i] = 1'b0;
                            if (m_pend[i]) begin
                                m_half[i] = m_pend_half[i];
                                m_inv[i]  = m_inv_pend[i];
                                m_pend[i] = 1'b0;
                            end
                        end
                        m_rem[i] = m_half[i];
                    end
                end
            end
            if (hit) begin
                m_pend_half[ch] = div + 1;
                m_inv_pend[ch]  = inv;
                m_pend[ch]      = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit en, input bit sy, input bit we, input int ch,
                         input int div, input bit inv);
        bit inv_eff = inv;
`ifndef CLKGEN_INVERT_EN
        inv_eff = 1'b0;
`endif
        @(negedge clock);
        enable  = en;
        sync    = sy;
        cfg_we  = we;
        cfg_ch  = 3'(ch);
        cfg_div = DIV_W'(div);
        cfg_inv = inv_eff;
        @(posedge clock);
        model_step(en, sy, we, ch, div, inv_eff);
        #1;
        check("clk_out",  32'(clk_out),  32'(exp_clk()));
        check("tick",     32'(tick),     32'(exp_tick()));
        check("cfg_busy", 32'(cfg_busy), 32'(exp_busy()));
        check("locked",   32'(locked),   32'(m_lock));
        for (int i = 0; i < NUM_CH; i++) tick_cnt[i] += int'(tick[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_default_ratios(input string tag);
        for (int i = 0; i < NUM_CH; i++) tick_cnt[i] = 0;
        idle(32);
        check({tag, "_ticks_ch0"}, 32'(tick_cnt[0]), 32'd16);
        check({tag, "_ticks_ch1"}, 32'(tick_cnt[1]), 32'd8);
        check({tag, "_ticks_ch2"}, 32'(tick_cnt[2]), 32'd4);
        check({tag, "_ticks_ch3"}, 32'(tick_cnt[3]), 32'd2);
        check({tag, "_locked"},    32'(locked),      32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        sync    = 1'b0;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;
        cfg_inv = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_clk_out",  32'(clk_out),  32'd0);
        check("rst_tick",     32'(tick),     32'd0);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        check("rst_locked",   32'(locked),   32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Default cascade ratios /2 /4 /8 /16 after reset release
        check_default_ratios("boot");

        // Reprogram ch1 while its output is high
        idle(2);
        cycle(1'b1, 1'b0, 1'b1, 1, 3, 1'b0);
        check("ch1_write_busy", 32'(cfg_busy), 32'd1);
        idle(24);

        // Two writes to ch2 before apply: last one wins
        cycle(1'b1, 1'b0, 1'b1, 2, 1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 2, 5, 1'b0);
        check("ch2_double_busy", 32'(cfg_busy), 32'd1);
        idle(40);

        // Sync realign
        idle(7);
        cycle(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        check("sync_clk_out", 32'(clk_out), 32'd0);
        check("sync_locked",  32'(locked),  32'd0);
        idle(20);

        // Enable low freezes everything; out-of-range write ignored
        idle(3);
        frozen = clk_out;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, (k == 1), 5, 7, 1'b0);
            check("freeze_clk_out", 32'(clk_out),  32'(frozen));
            check("freeze_tick",    32'(tick),     32'd0);
            check("freeze_busy",    32'(cfg_busy), 32'd0);
        end
        idle(10);

        // Random traffic
        repeat (600) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-period with a pending write
        cycle(1'b1, 1'b0, 1'b1, 0, 5, 1'b0);
        check("prerst_busy", 32'(cfg_busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_clk_out",  32'(clk_out),  32'd0);
        check("midrst_tick",     32'(tick),     32'd0);
        check("midrst_cfg_busy", 32'(cfg_busy), 32'd0);
        check("midrst_locked",   32'(locked),   32'd0);
        model_reset();
        enable = 1'b0;
        cfg_we = 1'b0;
        sync   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        check_default_ratios("rerst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
